fp_round_pipe: RTL and testbench
================================

# fp_round_pipe

Parametrised, two-stage pipelined IEEE-754 rounding and packing unit for the FPU datapath. It takes an unrounded sign/exponent/mantissa triple with guard/round/sticky bits and applies the five RISC-V rounding modes. It handles mantissa carry-out, exponent overflow, subnormal-to-normal promotion and special-class pass-through, then emits a packed float. A valid/ready handshake sits on both sides, so it drops between the add/mul normaliser and the FPU writeback without extra buffering.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; packed result is 1+EXP_W+MAN_W bits
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous pipeline kill; clears both stage valids
- in_valid  in  1  input beat present
- in_ready  out  1  unit accepts a beat this cycle
- in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 are treated as RNE
- in_cls  in  2  class: 00 finite, 01 zero, 10 infinity, 11 NaN
- in_s  in  1  sign
- in_e  in  EXP_W  biased exponent; 0 means subnormal
- in_m  in  MAN_W+4  {hidden, fraction[MAN_W-1:0], guard, round, sticky}; sticky is pre-ORed
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts the result
- out_res  out  1+EXP_W+MAN_W  packed {sign, exp, fraction}
- out_flags  out  3  {OF, UF, NX}

## Operation
- lsb = in_m[3]; g/r/s = in_m[2]/in_m[1]/in_m[0]; inexact = g|r|s.
- The increment decision (inc) depends on the mode:
  - RNE: g & (r|s|lsb).
  - RTZ: 0.
  - RDN: s_in & inexact.
  - RUP: !s_in & inexact.
  - RMM: g.
- Magnitude rounding only. There is never a decrement; RDN on a negative value rounds away from zero.
- The sum is {hidden, fraction} + inc, computed MAN_W+2 bits wide.
  - Carry out of the hidden position: fraction becomes 0 and exponent becomes in_e+1.
  - in_e==0 and the sum sets the hidden bit: exponent becomes 1 (subnormal promoted to min normal).
- Overflow applies when the post-round exponent is all-ones and the class is finite; it sets OF=1 and NX=1.
  - Result is infinity for RNE, RMM, RUP when positive, and RDN when negative.
  - Otherwise the result is max finite: exp all-ones-minus-1, fraction all ones.
- Underflow: UF=1 when the post-round exponent is 0 and inexact is set.
- Special classes ignore in_e/in_m and raise no flags:
  - zero gives {in_s, 0, 0};
  - infinity gives {in_s, all-ones, 0};
  - NaN gives canonical {0, all-ones, 1 followed by 0s}.
- Stage 1 (S1) registers the class, sign, inc decision, the MAN_W+2 sum, in_e and inexact.
- Stage 2 (S2) performs exponent adjust, overflow select, packing and flags.

## Timing
- Latency is 2 cycles from an accepted input to out_valid, with no stall.
- Throughput is 1 beat per cycle.
- Handshake:
  - S2 advances when !s2_valid or out_ready.
  - S1 advances when !s1_valid or S2 advances.
  - in_ready = S1 advances; it is purely combinational from out_ready and the valids.
- A beat transfers on valid & ready. When out_valid=1 && !out_ready, out_res and out_flags hold stable.
- Order is preserved. No beat is dropped or duplicated under any stall pattern.
- reset or flush clears s1_valid and s2_valid in that cycle. out_valid=0, out_res=0 and out_flags=0 from the next cycle.
  - This applies mid-operation: in-flight beats are discarded.
  - reset and flush have equal effect; a simultaneous input beat is also discarded.
- in_ready=1 from the cycle after reset deasserts.

## Configuration
- FP_ROUND_FLAGS_EN defined: out_flags computed as above.
- FP_ROUND_FLAGS_EN undefined:
  - out_flags is tied to 0 and the flag logic and registers are removed;
  - the overflow result selection is still performed;
  - the port list is unchanged.

## Structure
- Shared package fpu_pkg holds:
  - the rounding-mode localparams RM_RNE..RM_RMM;
  - the class encodings CLS_FIN/CLS_ZERO/CLS_INF/CLS_NAN;
  - the flag bit indices.
- One sub-module, fp_round_inc: the combinational inc decision from (rm, s, lsb, g, r, s). It is reused by the int-convert path.

## Test plan
Values are for EXP_W=8, MAN_W=23; in_m is given as 27-bit hex.
- RNE tie, odd lsb: s=0, e=0x7F, m=0x400000C → out_res 0x3F800002, flags NX=1, 2 cycles after accept.
- RNE tie, even lsb: e=0x7F, m=0x4000004 → 0x3F800000, NX=1.
- RNE carry-out: e=0x7F, m=0x7FFFFFC → 0x40000000.
  - The same input with RTZ → 0x3FFFFFFF.
- Overflow: e=0xFE, m=0x7FFFFFC.
  - RNE → 0x7F800000, OF=1, NX=1.
  - RTZ → 0x7F7FFFFF.
  - s=1, RUP → 0xFF7FFFFF.
- Subnormal promotion: e=0, m=0x3FFFFFC, RNE → 0x00800000, UF=0, NX=1.
  - m=0x0000004 with RUP → 0x00000001, UF=1.
- Backpressure, flush and specials:
  - Stream 4 beats with out_ready low for 3 cycles: in_ready drops once both stages are full, and all 4 results appear in order.
  - Assert flush with 2 beats in flight: no out_valid follows.
  - NaN class → 0x7FC00000, flags 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU encodings: rounding modes, operand classes, flag bit positions.
// out_flags is live only when FP_ROUND_FLAGS_EN is defined.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [1:0] CLS_FIN  = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/fp_round_pipe_if.sv
// Upstream/downstream valid-ready bundle of the rounding pipe.
// slave is the rounder side, master is the surrounding datapath.
interface fp_round_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             in_rm;
  logic [1:0]             in_cls;
  logic                   in_s;
  logic [EXP_W-1:0]       in_e;
  logic [MAN_W+3:0]       in_m;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_res;
  logic [2:0]             out_flags;

  modport master (
    output in_valid, in_rm, in_cls, in_s, in_e, in_m, out_ready,
    input  in_ready, out_valid, out_res, out_flags
  );

  modport slave (
    input  in_valid, in_rm, in_cls, in_s, in_e, in_m, out_ready,
    output in_ready, out_valid, out_res, out_flags
  );
endinterface

// File: rtl/fp_round_inc.sv
// Round-increment decision for the five RISC-V modes.
// Unused mode encodings fall back to RNE.
module fp_round_inc
  import fpu_pkg::*;
(
  input  logic [2:0] rm_i,
  input  logic       s_i,
  input  logic       lsb_i,
  input  logic       g_i,
  input  logic       r_i,
  input  logic       st_i,
  output logic       inc_o
);
  logic nx;
  assign nx = g_i | r_i | st_i;

  always_comb begin
    inc_o = 1'b0;
    unique case (1'b1)
      (rm_i == RM_RTZ): inc_o = 1'b0;
      (rm_i == RM_RDN): inc_o = s_i & nx;
      (rm_i == RM_RUP): inc_o = !s_i & nx;
      (rm_i == RM_RMM): inc_o = g_i;
      default:          inc_o = g_i & (r_i | st_i | lsb_i);
    endcase
  end
endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 round-and-pack unit with valid/ready on both sides.
// FP_ROUND_FLAGS_EN enables the {OF,UF,NX} flag path.
module fp_round_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  fp_round_pipe_if.slave io
);
  logic kill, s1_adv, s2_adv, inc;
  logic s1_valid_q, s2_valid_q;

  assign kill   = reset | flush;
  assign s2_adv = !s2_valid_q | io.out_ready;
  assign s1_adv = !s1_valid_q | s2_adv;
  assign io.in_ready  = s1_adv;
  assign io.out_valid = s2_valid_q;

  fp_round_inc u_inc (
    .rm_i (io.in_rm),
    .s_i  (io.in_s),
    .lsb_i(io.in_m[3]),
    .g_i  (io.in_m[2]),
    .r_i  (io.in_m[1]),
    .st_i (io.in_m[0]),
    .inc_o(inc)
  );

  logic [MAN_W+1:0] sum_d, s1_sum_q;
  logic [1:0]       s1_cls_q;
  logic [2:0]       s1_rm_q;
  logic             s1_s_q;
  logic [EXP_W-1:0] s1_e_q;

  assign sum_d = {1'b0, io.in_m[MAN_W+3:3]}
               + {{(MAN_W+1){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (kill)        s1_valid_q <= 1'b0;
    else if (s1_adv) s1_valid_q <= io.in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && io.in_valid) begin
      s1_sum_q <= sum_d;
      s1_cls_q <= io.in_cls;
      s1_rm_q  <= io.in_rm;
      s1_s_q   <= io.in_s;
      s1_e_q   <= io.in_e;
    end
  end

  logic [EXP_W-1:0] exp_r;
  logic [MAN_W-1:0] frac_r;
  logic             ovf, to_inf;
  logic [EXP_W+MAN_W:0] res_d, s2_res_q;

  always_comb begin
    exp_r  = s1_e_q;
    frac_r = s1_sum_q[MAN_W-1:0];
    if (s1_sum_q[MAN_W+1]) begin
      exp_r  = s1_e_q + 1'b1;
      frac_r = '0;
    end else if (s1_e_q == '0 && s1_sum_q[MAN_W]) begin
      exp_r  = {{(EXP_W-1){1'b0}}, 1'b1};
    end
  end

  assign ovf = (exp_r == '1) && (s1_cls_q == CLS_FIN);

  // Directed modes saturate to max finite when rounding toward zero.
  always_comb begin
    to_inf = 1'b1;
    unique case (1'b1)
      (s1_rm_q == RM_RTZ): to_inf = 1'b0;
      (s1_rm_q == RM_RDN): to_inf = s1_s_q;
      (s1_rm_q == RM_RUP): to_inf = !s1_s_q;
      default:             to_inf = 1'b1;
    endcase
  end

  always_comb begin
    res_d = {s1_s_q, exp_r, frac_r};
    unique case (1'b1)
      (s1_cls_q == CLS_ZERO):
        res_d = {s1_s_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      (s1_cls_q == CLS_INF):
        res_d = {s1_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      (s1_cls_q == CLS_NAN):
        res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      ovf:
        res_d = to_inf
          ? {s1_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
          : {s1_s_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_res_q <= res_d;
    end
  end

  assign io.out_res = s2_res_q;

`ifdef FP_ROUND_FLAGS_EN
  logic       s1_nx_q, fin;
  logic [2:0] flags_d, s2_flags_q;

  always_ff @(posedge clk) begin
    if (s1_adv && io.in_valid)
      s1_nx_q <= |io.in_m[2:0];
  end

  assign fin = (s1_cls_q == CLS_FIN);

  always_comb begin
    flags_d          = '0;
    flags_d[FLAG_OF] = ovf;
    flags_d[FLAG_UF] = fin && (exp_r == '0) && s1_nx_q;
    flags_d[FLAG_NX] = fin && (s1_nx_q | ovf);
  end

  always_ff @(posedge clk) begin
    if (kill)
      s2_flags_q <= '0;
    else if (s2_adv && s1_valid_q)
      s2_flags_q <= flags_d;
  end

  assign io.out_flags = s2_flags_q;
`else
  assign io.out_flags = '0;
`endif
endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe (EXP_W=8, MAN_W=23).
// Flag expectations follow FP_ROUND_FLAGS_EN.
module tb_fp_round_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic reset, flush;
  always #5 clk = ~clk;

  fp_round_pipe_if io ();

  fp_round_pipe dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .io   (io)
  );

  typedef struct packed {
    logic [2:0]  rm;
    logic [1:0]  cls;
    logic        s;
    logic [7:0]  e;
    logic [26:0] m;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  fl;
  } exp_t;

  vec_t vecs [18];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   push_en = 1'b1;
  bit   done;

  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] efl(logic [2:0] f);
`ifdef FP_ROUND_FLAGS_EN
    return f;
`else
    return 3'b000 & f;
`endif
  endfunction

  logic        stall_p = 1'b0;
  logic [31:0] hold_res;
  logic [2:0]  hold_fl;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (stall_p) begin
      chk("hold_res", io.out_res, hold_res);
      chk("hold_flags", {29'd0, io.out_flags}, {29'd0, hold_fl});
    end
    stall_p  = io.out_valid && !io.out_ready && !reset && !flush;
    hold_res = io.out_res;
    hold_fl  = io.out_flags;
    if (io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {31'd0, io.out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("res", io.out_res, e.res);
        chk("flags", {29'd0, io.out_flags}, {29'd0, e.fl});
      end
    end
  end

  task automatic send(input vec_t v, output int t0);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_rm    = v.rm;
    io.in_cls   = v.cls;
    io.in_s     = v.s;
    io.in_e     = v.e;
    io.in_m     = v.m;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (io.in_ready) begin
        t0 = cyc;
        @(posedge clk);
        if (push_en) sb.push_back('{v.res, efl(v.fl)});
        return;
      end
      @(negedge clk);
    end
    chk("send_timeout", {31'd0, io.in_ready}, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    int t0;
    vecs = '{
      '{RM_RNE, CLS_FIN, 1'b0, 8'h7F, 27'h400000C, 32'h3F800002, 3'b001},
      '{RM_RNE, CLS_FIN, 1'b0, 8'h7F, 27'h4000004, 32'h3F800000, 3'b001},
      '{RM_RNE, CLS_FIN, 1'b0, 8'h7F, 27'h7FFFFFC, 32'h40000000, 3'b001},
      '{RM_RTZ, CLS_FIN, 1'b0, 8'h7F, 27'h7FFFFFC, 32'h3FFFFFFF, 3'b001},
      '{RM_RNE, CLS_FIN, 1'b0, 8'hFE, 27'h7FFFFFC, 32'h7F800000, 3'b101},
      '{RM_RTZ, CLS_FIN, 1'b0, 8'hFE, 27'h7FFFFFC, 32'h7F7FFFFF, 3'b001},
      '{RM_RUP, CLS_FIN, 1'b1, 8'hFE, 27'h7FFFFFC, 32'hFF7FFFFF, 3'b001},
      '{RM_RNE, CLS_FIN, 1'b0, 8'h00, 27'h3FFFFFC, 32'h00800000, 3'b001},
      '{RM_RUP, CLS_FIN, 1'b0, 8'h00, 27'h0000004, 32'h00000001, 3'b011},
      '{RM_RNE, CLS_NAN, 1'b1, 8'h12, 27'h1234567, 32'h7FC00000, 3'b000},
      '{RM_RUP, CLS_ZERO, 1'b1, 8'h7F, 27'h400000F, 32'h80000000, 3'b000},
      '{RM_RNE, CLS_INF, 1'b0, 8'h01, 27'h0000007, 32'h7F800000, 3'b000},
      '{RM_RDN, CLS_FIN, 1'b1, 8'h7F, 27'h4000001, 32'hBF800001, 3'b001},
      '{RM_RMM, CLS_FIN, 1'b0, 8'h7F, 27'h4000004, 32'h3F800001, 3'b001},
      '{RM_RNE, CLS_FIN, 1'b0, 8'h7F, 27'h4000008, 32'h3F800001, 3'b000},
      '{3'b111, CLS_FIN, 1'b0, 8'h7F, 27'h400000C, 32'h3F800002, 3'b001},
      '{RM_RDN, CLS_FIN, 1'b1, 8'hFE, 27'h7FFFFFC, 32'hFF800000, 3'b101},
      '{RM_RTZ, CLS_FIN, 1'b0, 8'h00, 27'h0000008, 32'h00000001, 3'b000}
    };

    reset = 1'b1;
    flush = 1'b0;
    io.in_valid = 1'b0;
    io.in_rm = '0;
    io.in_cls = '0;
    io.in_s = 1'b0;
    io.in_e = '0;
    io.in_m = '0;
    io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_res", io.out_res, 32'd0);
    chk("rst_flags", {29'd0, io.out_flags}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_rst", {31'd0, io.in_ready}, 32'd1);

    send(vecs[0], t0);
    idle();
    #1;
    for (int k = 0; k < 10; k++) begin
      if (io.out_valid) break;
      @(negedge clk);
      #1;
    end
    chk("latency", cyc - t0, 32'd2);
    drain();

    for (int i = 0; i < 18; i++) send(vecs[i], t0);
    idle();
    drain();

    fork
      begin
        for (int i = 0; i < 4; i++) send(vecs[i + 4], t0);
        idle();
      end
      begin
        @(negedge clk);
        io.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("bp_in_ready", {31'd0, io.in_ready}, 32'd0);
        @(negedge clk);
        io.out_ready = 1'b1;
      end
    join
    drain();

    io.out_ready = 1'b0;
    push_en = 1'b0;
    send(vecs[2], t0);
    send(vecs[3], t0);
    @(negedge clk);
    io.in_rm  = vecs[0].rm;
    io.in_cls = vecs[0].cls;
    io.in_e   = vecs[0].e;
    io.in_m   = vecs[0].m;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    #1;
    chk("flush_res", io.out_res, 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("flush_valid", {31'd0, io.out_valid}, 32'd0);
      @(negedge clk);
      #1;
    end
    push_en = 1'b1;

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(vecs[i % 18], t0);
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          io.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    io.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
